axi_slave_packer: RTL and testbench
===================================

// Module: axi_slave_packer
// PURPOSE
//   AXI4 slave read-channel packer: serves host reads of the Output Buffer. Fetches 512-bit SRAM rows
//   (ARRAY_WIDTH x 32b), slices them into AXI beats, returns them on R. Read-side counterpart of the
//   host write unpacker; sits between the AXI interconnect and the Output Buffer read port.
//   Int32 mode: words pass through. Int8 mode: each word saturated to signed 8 bit.
// PARAMETERS
//   AXI_DATA_WIDTH   64  R beat width; legal values 32, 64, 128 (elaboration assertion otherwise)
//   SRAM_DATA_WIDTH  32  element width in the buffer
//   ARRAY_WIDTH      16  elements per SRAM row
//   ADDR_WIDTH       10  SRAM row-address width
// PORTS
//   clk                     in   1    clock
//   rst                     in   1    reset rst, synchronous, active-high
//   cfg_data_type_is_int32  in   1    1: 32b passthrough, 0: saturate to int8; sampled at AR handshake
//   araddr                  in   32   byte address; row = araddr[ADDR_WIDTH+5:6], bits [5:0] ignored
//   arlen                   in   8    beats-1
//   arsize                  in   3    ignored (full-width beats)
//   arburst                 in   2    2'b01 INCR supported; others -> SLVERR
//   arvalid / arready       in/out 1  AR handshake
//   rdata                   out  AXI_DATA_WIDTH  packed beat
//   rresp                   out  2    00 OKAY, 10 SLVERR
//   rlast                   out  1    final beat of burst
//   rvalid / rready         out/in 1  R handshake
//   host_rd_addr            out  ADDR_WIDTH  SRAM row address
//   host_rd_en              out  1    read strobe, registered
//   host_rd_data            in   SRAM_DATA_WIDTH x [ARRAY_WIDTH]  row data, valid 1 cycle after host_rd_en
// BEHAVIOUR
//   Reset: state IDLE; arready=1, rvalid=0, rlast=0, rresp=00, rdata=0, host_rd_en=0, host_rd_addr=0,
//     row buffer and all counters 0. Reset mid-burst aborts: no further beats, no SRAM reads.
//   BEATS_PER_ROW: int32 = 512/AXI_DATA_WIDTH (8 @64b); int8 = 128/AXI_DATA_WIDTH (2 @64b).
//   States: IDLE -> RD_REQ -> RD_WAIT -> R_DATA -> (RD_REQ | IDLE).
//   IDLE: arready=1. On arvalid: latch row addr, arlen, mode, err=(arburst!=01); beat_cnt=0,
//     beat_in_row=0; -> RD_REQ.
//   RD_REQ: host_rd_en=1 one cycle, host_rd_addr=row; -> RD_WAIT.
//   RD_WAIT: capture host_rd_data into row buffer; -> R_DATA.
//   R_DATA: rvalid=1; rdata/rlast/rresp stable while rvalid && !rready.
//     int32: rdata = elements [b*N32 +: N32], N32=AXI_DATA_WIDTH/32, b=beat_in_row.
//     int8: rdata byte j = sat8(element b*N8+j), N8=AXI_DATA_WIDTH/8; sat8: >127->8'h7F,
//       <-128->8'h80, else low byte. Element 0 in lowest lane.
//     rlast = (beat_cnt==arlen); rresp=err?10:00 on every beat (data still streamed).
//     On handshake: if rlast -> IDLE; elif beat_in_row==BEATS_PER_ROW-1 -> row+1, beat_in_row=0,
//       -> RD_REQ; else beat_in_row++. beat_cnt++.
//   Latency: AR handshake cycle T -> host_rd_en at T+1 -> first rvalid at T+3.
//     Row crossing: 2-cycle rvalid bubble. Back-to-back beats within a row at full rate.
//   Row address wraps modulo 2^ADDR_WIDTH (1023 -> 0), no error.
//   arlen up to 255; bursts may span many rows; partial final row allowed (unused slices dropped).
//   No outstanding transactions: arready=0 outside IDLE; next AR accepted cycle after final beat.
//   rready low for any duration: state, row buffer, SRAM port frozen.
// STRUCTURE
//   tc_axi_pkg: AXI_RESP_OKAY/SLVERR, AXI_BURST_INCR, rd_state_t enum, sat8() function.
//   Sub-module int8_saturator (32b in -> 8b out, combinational), one per int8 lane (generate).
//   Beat mux and counters in this module; no FIFO.
// TESTING
//   1. int32, araddr=0x40, arlen=7, row1 = words 0..15 -> host_rd_addr=1; 8 beats {w1,w0}..{w15,w14};
//      rlast on beat 8 only; first rvalid 3 cycles after AR handshake.
//   2. int8, row0 = {200,-300,5,-5,127,-128,0,1,...}, arlen=1 -> beat0 bytes 7F,80,05,FB,7F,80,00,01.
//   3. int32, araddr=0, arlen=15 -> rows 0 then 1 read; exactly 2-cycle rvalid gap between beat 8 and 9.
//   4. rready held low 5 cycles mid-burst -> rdata/rlast unchanged, no extra host_rd_en; 16 beats total.
//   5. araddr row 1023, int8, arlen=3 -> host_rd_addr 1023 then 0; arburst=2'b10 -> all rresp=10.
//   6. rst pulse at beat 3 of arlen=7 -> next cycle rvalid=0, arready=1; new AR then served normally.

Source files
------------

// File: rtl/axi_slave_packer_pkg.sv
// Shared AXI response/burst codes, read-path FSM states and int8 saturation helper.
package axi_slave_packer_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_R_DATA
  } rd_state_t;

  // Clamp a signed 32-bit element into the signed 8-bit range.
  function automatic logic [7:0] sat8(input logic signed [31:0] x);
    if (x > 32'sd127) begin
      return 8'h7F;
    end else if (x < -32'sd128) begin
      return 8'h80;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/axi_slave_packer_if.sv
// AXI4 read address / read data channels between the interconnect and the packer.
interface axi_slave_packer_if #(
  parameter int AXI_DATA_WIDTH = 64
);

  logic [31:0]               araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_slave_packer_int8_saturator.sv
// One int8 output lane: saturates a signed 32-bit buffer element to signed 8 bit.
module axi_slave_packer_int8_saturator
  import axi_slave_packer_pkg::*;
(
  input  logic signed [31:0] din,
  output logic        [7:0]  dout
);

  assign dout = sat8(din);

endmodule

// File: rtl/axi_slave_packer.sv
// AXI4 read-channel packer for the Output Buffer: fetches one SRAM row per
// RD_REQ, slices it into R beats (int32 passthrough or int8 saturated) and
// walks consecutive rows until the burst length is exhausted.
module axi_slave_packer
  import axi_slave_packer_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int ARRAY_WIDTH     = 16,
  parameter int ADDR_WIDTH      = 10
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       cfg_data_type_is_int32,
  axi_slave_packer_if.slave                          axi,
  output logic [ADDR_WIDTH-1:0]                      host_rd_addr,
  output logic                                       host_rd_en,
  input  logic [ARRAY_WIDTH-1:0][SRAM_DATA_WIDTH-1:0] host_rd_data
);

  localparam int N32    = AXI_DATA_WIDTH / SRAM_DATA_WIDTH;
  localparam int N8     = AXI_DATA_WIDTH / 8;
  localparam int BPR32  = ARRAY_WIDTH * SRAM_DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int BPR8   = ARRAY_WIDTH * 8 / AXI_DATA_WIDTH;
  localparam int ELEM_W = $clog2(ARRAY_WIDTH);

  if (!(AXI_DATA_WIDTH == 32 || AXI_DATA_WIDTH == 64 || AXI_DATA_WIDTH == 128)) begin : g_bad_axi_width
    $error("axi_slave_packer: AXI_DATA_WIDTH must be 32, 64 or 128");
  end
  if (SRAM_DATA_WIDTH != 32) begin : g_bad_sram_width
    $error("axi_slave_packer: SRAM_DATA_WIDTH must be 32");
  end

  rd_state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]      row, row_nxt;
  logic [7:0]                 len;
  logic [7:0]                 beat_cnt;
  logic [7:0]                 beat_in_row;
  logic [7:0]                 bpr_last;
  logic                       mode_i32;
  logic                       err;
  logic                       last;
  logic                       row_end;
  logic                       hs_r;
  logic [SRAM_DATA_WIDTH-1:0] row_buf [ARRAY_WIDTH];
  logic [AXI_DATA_WIDTH-1:0]  rdata32;
  logic [AXI_DATA_WIDTH-1:0]  rdata8;
  logic                       unused_ok;

  // Burst size and sub-word address bits carry no information for this slave.
  assign unused_ok = ^{axi.arsize, axi.araddr[31:ADDR_WIDTH+6], axi.araddr[5:0]};

  assign bpr_last = mode_i32 ? 8'(BPR32 - 1) : 8'(BPR8 - 1);
  assign last     = (beat_cnt == len);
  assign row_end  = (beat_in_row == bpr_last);
  assign hs_r     = (state == ST_R_DATA) && axi.rready;

  // Next-state, next-row and AXI handshake outputs.
  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rresp   = AXI_RESP_OKAY;
    unique case (state)
      ST_IDLE: begin
        axi.arready = 1'b1;
        if (axi.arvalid) begin
          state_nxt = ST_RD_REQ;
          row_nxt   = axi.araddr[ADDR_WIDTH+5:6];
        end
      end
      ST_RD_REQ:  state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: state_nxt = ST_R_DATA;
      ST_R_DATA: begin
        axi.rvalid = 1'b1;
        axi.rlast  = last;
        axi.rresp  = err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (axi.rready) begin
          if (last) begin
            state_nxt = ST_IDLE;
          end else if (row_end) begin
            // Row address wraps naturally at 2^ADDR_WIDTH.
            state_nxt = ST_RD_REQ;
            row_nxt   = row + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, burst bookkeeping and the registered SRAM request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      row          <= '0;
      len          <= '0;
      beat_cnt     <= '0;
      beat_in_row  <= '0;
      mode_i32     <= 1'b0;
      err          <= 1'b0;
      host_rd_en   <= 1'b0;
      host_rd_addr <= '0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      host_rd_en <= (state_nxt == ST_RD_REQ);
      if (state_nxt == ST_RD_REQ) begin
        host_rd_addr <= row_nxt;
      end
      if (state == ST_IDLE && axi.arvalid) begin
        len         <= axi.arlen;
        mode_i32    <= cfg_data_type_is_int32;
        err         <= (axi.arburst != AXI_BURST_INCR);
        beat_cnt    <= '0;
        beat_in_row <= '0;
      end
      if (hs_r) begin
        beat_cnt    <= beat_cnt + 8'd1;
        beat_in_row <= row_end ? 8'd0 : beat_in_row + 8'd1;
      end
    end
  end

  // Row buffer: captures SRAM data the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARRAY_WIDTH; i++) begin
        row_buf[i] <= '0;
      end
    end else if (state == ST_RD_WAIT) begin
      for (int i = 0; i < ARRAY_WIDTH; i++) begin
        row_buf[i] <= host_rd_data[i];
      end
    end
  end

  // int32 beat: N32 consecutive elements, lowest element in the lowest lane.
  for (genvar k = 0; k < N32; k++) begin : g_w32
    assign rdata32[k*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] =
      row_buf[ELEM_W'(int'(beat_in_row) * N32 + k)];
  end

  // int8 beat: N8 consecutive elements, each saturated into its own byte lane.
  for (genvar j = 0; j < N8; j++) begin : g_lane8
    logic [ELEM_W-1:0] idx;
    assign idx = ELEM_W'(int'(beat_in_row) * N8 + j);
    axi_slave_packer_int8_saturator u_sat (
      .din  (row_buf[idx]),
      .dout (rdata8[j*8 +: 8])
    );
  end

  assign axi.rdata = mode_i32 ? rdata32 : rdata8;

endmodule

// File: tb/tb_axi_slave_packer.sv
// Directed bench for axi_slave_packer: int32/int8 bursts, row crossing,
// back-pressure, address wrap, SLVERR bursts and mid-burst reset.
module tb_axi_slave_packer;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg = 1'b1;
  logic [9:0]       host_rd_addr;
  logic             host_rd_en;
  logic [15:0][31:0] host_rd_data;
  logic [15:0][31:0] mem [1024];
  int               passed = 0;
  int               total  = 0;
  int               rd_en_cnt = 0;

  axi_slave_packer_if #(.AXI_DATA_WIDTH(64)) axi ();

  axi_slave_packer #(
    .AXI_DATA_WIDTH  (64),
    .SRAM_DATA_WIDTH (32),
    .ARRAY_WIDTH     (16),
    .ADDR_WIDTH      (10)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .cfg_data_type_is_int32 (cfg),
    .axi                    (axi),
    .host_rd_addr           (host_rd_addr),
    .host_rd_en             (host_rd_en),
    .host_rd_data           (host_rd_data)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency.
  always @(posedge clk) if (host_rd_en) host_rd_data <= mem[host_rd_addr];

  always @(posedge clk) if (host_rd_en) rd_en_cnt <= rd_en_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running required done");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic ar_req(input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic mode);
    int n = 0;
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arburst = burst;
    axi.arsize  = 3'd3;
    cfg         = mode;
    axi.arvalid = 1'b1;
    while (axi.arready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (axi.arready !== 1'b1) check("arready_timeout", 64'(axi.arready), 64'd1);
    tick();
    axi.arvalid = 1'b0;
    cfg         = ~mode;
  endtask

  task automatic get_beat(output logic [63:0] d, output logic l, output logic [1:0] r, output int w);
    axi.rready = 1'b1;
    w = 0;
    while (axi.rvalid !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    if (axi.rvalid !== 1'b1) check("rvalid_timeout", 64'(axi.rvalid), 64'd1);
    d = axi.rdata;
    l = axi.rlast;
    r = axi.rresp;
    tick();
  endtask

  initial begin
    logic [63:0] d, snap_d;
    logic        l, snap_l;
    logic [1:0]  r;
    int          w, en0;

    axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd3; axi.arburst = 2'b01;
    axi.arvalid = 1'b0; axi.rready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      mem[1][i]    = 32'(i);
      mem[1023][i] = 32'(i);
    end
    mem[0][0]  = 32'sd200;   mem[0][1]  = -32'sd300; mem[0][2]  = 32'sd5;   mem[0][3]  = -32'sd5;
    mem[0][4]  = 32'sd127;   mem[0][5]  = -32'sd128; mem[0][6]  = 32'sd0;   mem[0][7]  = 32'sd1;
    mem[0][8]  = 32'sd128;   mem[0][9]  = -32'sd129; mem[0][10] = -32'sd1;  mem[0][11] = 32'sd100;
    mem[0][12] = 32'sd32767; mem[0][13] = -32'sd2;   mem[0][14] = 32'sd64;  mem[0][15] = -32'sd64;

    // Reset state
    tick(); tick();
    check("rst_arready", 64'(axi.arready), 64'd1);
    check("rst_rvalid",  64'(axi.rvalid),  64'd0);
    check("rst_rlast",   64'(axi.rlast),   64'd0);
    check("rst_rresp",   64'(axi.rresp),   64'd0);
    check("rst_rdata",   axi.rdata,        64'd0);
    check("rst_rd_en",   64'(host_rd_en),  64'd0);
    check("rst_rd_addr", 64'(host_rd_addr), 64'd0);
    rst = 1'b0;
    tick();

    // 1: int32 single row, row 1
    ar_req(32'h40, 8'd7, 2'b01, 1'b1);
    check("t1_rd_en",   64'(host_rd_en),   64'd1);
    check("t1_rd_addr", 64'(host_rd_addr), 64'd1);
    check("t1_arready_busy", 64'(axi.arready), 64'd0);
    for (int b = 0; b < 8; b++) begin
      get_beat(d, l, r, w);
      check($sformatf("t1_data%0d", b), d, {32'(2*b+1), 32'(2*b)});
      check($sformatf("t1_last%0d", b), 64'(l), 64'(b == 7));
      check($sformatf("t1_wait%0d", b), 64'(w), (b == 0) ? 64'd2 : 64'd0);
    end
    check("t1_rresp", 64'(r), 64'd0);
    check("t1_arready_after", 64'(axi.arready), 64'd1);

    // 2: int8 saturation, row 0
    ar_req(32'h0, 8'd1, 2'b01, 1'b0);
    get_beat(d, l, r, w);
    check("t2_beat0", d, 64'h0100_807F_FB05_807F);
    check("t2_last0", 64'(l), 64'd0);
    get_beat(d, l, r, w);
    check("t2_beat1", d, 64'hC040_FE7F_64FF_807F);
    check("t2_last1", 64'(l), 64'd1);

    // 3: int32 two rows, 2-cycle bubble at the row crossing
    en0 = rd_en_cnt;
    ar_req(32'h0, 8'd15, 2'b01, 1'b1);
    for (int b = 0; b < 16; b++) begin
      get_beat(d, l, r, w);
      check($sformatf("t3_data%0d", b), d, {mem[b/8][2*(b%8)+1], mem[b/8][2*(b%8)]});
      if (b == 8) check("t3_gap", 64'(w), 64'd2);
      if (b == 15) check("t3_last", 64'(l), 64'd1);
    end
    check("t3_rd_en_count", 64'(rd_en_cnt - en0), 64'd2);

    // 4: back-pressure for 5 cycles mid-burst
    en0 = rd_en_cnt;
    ar_req(32'h0, 8'd15, 2'b01, 1'b1);
    for (int b = 0; b < 16; b++) begin
      if (b == 4) begin
        axi.rready = 1'b0;
        snap_d = axi.rdata;
        snap_l = axi.rlast;
        check("t4_rvalid_pre", 64'(axi.rvalid), 64'd1);
        for (int s = 0; s < 5; s++) tick();
        check("t4_rdata_hold", axi.rdata, snap_d);
        check("t4_rlast_hold", 64'(axi.rlast), 64'(snap_l));
        check("t4_rvalid_hold", 64'(axi.rvalid), 64'd1);
      end
      get_beat(d, l, r, w);
      check($sformatf("t4_data%0d", b), d, {mem[b/8][2*(b%8)+1], mem[b/8][2*(b%8)]});
      check($sformatf("t4_last%0d", b), 64'(l), 64'(b == 15));
    end
    check("t4_rd_en_count", 64'(rd_en_cnt - en0), 64'd2);

    // 5: row 1023 wraps to row 0, int8, non-INCR burst -> SLVERR
    ar_req(32'h0000_FFC0, 8'd3, 2'b10, 1'b0);
    check("t5_rd_addr0", 64'(host_rd_addr), 64'd1023);
    get_beat(d, l, r, w);
    check("t5_beat0", d, 64'h0706_0504_0302_0100);
    check("t5_resp0", 64'(r), 64'd2);
    get_beat(d, l, r, w);
    check("t5_beat1", d, 64'h0F0E_0D0C_0B0A_0908);
    check("t5_resp1", 64'(r), 64'd2);
    check("t5_wrap_en",   64'(host_rd_en),   64'd1);
    check("t5_wrap_addr", 64'(host_rd_addr), 64'd0);
    get_beat(d, l, r, w);
    check("t5_beat2", d, 64'h0100_807F_FB05_807F);
    check("t5_resp2", 64'(r), 64'd2);
    get_beat(d, l, r, w);
    check("t5_beat3", d, 64'hC040_FE7F_64FF_807F);
    check("t5_resp3", 64'(r), 64'd2);
    check("t5_last3", 64'(l), 64'd1);

    // 6: reset at beat 3 aborts, then a fresh burst is served
    ar_req(32'h40, 8'd7, 2'b01, 1'b1);
    for (int b = 0; b < 3; b++) begin
      get_beat(d, l, r, w);
      check($sformatf("t6_data%0d", b), d, {32'(2*b+1), 32'(2*b)});
    end
    check("t6_rvalid_beat3", 64'(axi.rvalid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rvalid_post", 64'(axi.rvalid), 64'd0);
    check("t6_arready_post", 64'(axi.arready), 64'd1);
    check("t6_rlast_post", 64'(axi.rlast), 64'd0);
    en0 = rd_en_cnt;
    tick(); tick(); tick();
    check("t6_no_reads", 64'(rd_en_cnt - en0), 64'd0);
    check("t6_rvalid_idle", 64'(axi.rvalid), 64'd0);
    ar_req(32'h40, 8'd1, 2'b01, 1'b1);
    check("t6_rd_addr", 64'(host_rd_addr), 64'd1);
    get_beat(d, l, r, w);
    check("t6_new_data0", d, {32'd1, 32'd0});
    check("t6_new_wait0", 64'(w), 64'd2);
    get_beat(d, l, r, w);
    check("t6_new_data1", d, {32'd3, 32'd2});
    check("t6_new_last1", 64'(l), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
